nic_cmd_responder: RTL and testbench



---
 rtl/nic_cmd_responder.sv | 170 +++++++++++++++++
 tb/tb_nic_cmd_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_cmd_responder.sv
// Egress endpoint for the NIC outbound command interface: queues commands and
// services one at a time over a bandwidth-limited link, returning in-order completions.
module nic_cmd_responder #(
  parameter int CmdIdWidth     = 8,
  parameter int LenWidth       = 32,
  parameter int MaxOutstanding = 4,
  parameter int BytesPerCycle  = 64,
  parameter int FixedLatency   = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_req_valid_i,
  output logic                  cmd_req_ready_o,
  input  logic [CmdIdWidth-1:0] cmd_req_id_i,
  input  logic [LenWidth-1:0]   cmd_req_length_i,
  output logic                  cmd_resp_valid_o,
  input  logic                  cmd_resp_ready_i,
  output logic [CmdIdWidth-1:0] cmd_resp_id_o,
  output logic                  busy_o,
  output logic [31:0]           cmds_completed_o,
  output logic [63:0]           bytes_sent_o
);

  // state | meaning
  // IDLE  | nothing in service, waiting for a queued command
  // XFER  | command in service, timer counting down
  // RESP  | completion presented, waiting for the handshake
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int OW  = $clog2(MaxOutstanding + 1);
  localparam int PW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int BSH = $clog2(BytesPerCycle);
  localparam int CW  = LenWidth + 1;
  localparam int FW  = $clog2(FixedLatency + 1);
  localparam int TW  = ((CW > FW) ? CW : FW) + 1;

  logic [1:0]            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CmdIdWidth-1:0] cur_id_q, cur_id_d;
  logic [LenWidth-1:0]   cur_len_q, cur_len_d;
  logic [CmdIdWidth-1:0] resp_id_q, resp_id_d;
  logic [OW-1:0]         out_q, out_d;
  logic [OW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [31:0]           cmds_q, cmds_d;
  logic [63:0]           bytes_q, bytes_d;

  logic [CmdIdWidth-1:0] fifo_id_q  [MaxOutstanding];
  logic [LenWidth-1:0]   fifo_len_q [MaxOutstanding];

  logic          req_hs, resp_hs, pop;
  logic [CW-1:0] len_sum, len_ceil;
  logic [TW-1:0] svc_raw, svc_len;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_req_ready_o  = (out_q < OW'(MaxOutstanding));
  assign cmd_resp_valid_o = (state_q == S_RESP);
  assign cmd_resp_id_o    = resp_id_q;
  assign busy_o           = (out_q != '0);
  assign cmds_completed_o = cmds_q;
  assign bytes_sent_o     = bytes_q;

  assign req_hs  = cmd_req_valid_i & cmd_req_ready_o;
  assign resp_hs = cmd_resp_valid_o & cmd_resp_ready_i;
  assign pop     = (fifo_cnt_q != '0) &
                   ((state_q == S_IDLE) | ((state_q == S_RESP) & resp_hs));

  // Extra bit keeps the round-up from overflowing at the maximum length.
  assign len_sum  = {1'b0, fifo_len_q[rd_ptr_q]} + CW'(BytesPerCycle - 1);
  assign len_ceil = len_sum >> BSH;
  assign svc_raw  = TW'(FixedLatency) + TW'(len_ceil);
  assign svc_len  = (svc_raw == '0) ? TW'(1) : svc_raw;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cur_id_d   = cur_id_q;
    cur_len_d  = cur_len_q;
    resp_id_d  = resp_id_q;
    cmds_d     = cmds_q;
    bytes_d    = bytes_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    out_d      = out_q;
    fifo_cnt_d = fifo_cnt_q;

    case (state_q)
      S_IDLE: if (pop) state_d = S_XFER;
      S_XFER: begin
        if (timer_q == TW'(1)) begin
          resp_id_d = cur_id_q;
          state_d   = S_RESP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_RESP: begin
        if (resp_hs) begin
          cmds_d  = cmds_q + 32'd1;
          bytes_d = bytes_q + 64'(cur_len_q);
          state_d = pop ? S_XFER : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      timer_d   = svc_len;
      cur_id_d  = fifo_id_q[rd_ptr_q];
      cur_len_d = fifo_len_q[rd_ptr_q];
      rd_ptr_d  = ptr_inc(rd_ptr_q);
    end
    if (req_hs) wr_ptr_d = ptr_inc(wr_ptr_q);

    case ({req_hs, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + OW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - OW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case ({req_hs, resp_hs})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cur_id_q   <= '0;
      cur_len_q  <= '0;
      resp_id_q  <= '0;
      cmds_q     <= '0;
      bytes_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      out_q      <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cur_id_q   <= cur_id_d;
      cur_len_q  <= cur_len_d;
      resp_id_q  <= resp_id_d;
      cmds_q     <= cmds_d;
      bytes_q    <= bytes_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      out_q      <= out_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by fifo_cnt_q.
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      fifo_id_q[wr_ptr_q]  <= cmd_req_id_i;
      fifo_len_q[wr_ptr_q] <= cmd_req_length_i;
    end
  end

endmodule

// File: tb/tb_nic_cmd_responder.sv
// Self-checking bench for nic_cmd_responder: scoreboard of accepted commands
// checked against in-order completions, plus latency, backpressure and reset scenarios.
module tb_nic_cmd_responder;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] len;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, resp_ready = 1'b0;
  logic [7:0]  req_id = '0;
  logic [31:0] req_len = '0;
  logic        req_ready, resp_valid, busy;
  logic [7:0]  resp_id;
  logic [31:0] cmds;
  logic [63:0] bytes_sent;

  logic        req_valid0 = 1'b0, resp_ready0 = 1'b1;
  logic [7:0]  req_id0 = '0;
  logic [31:0] req_len0 = '0;
  logic        req_ready0, resp_valid0, busy0;
  logic [7:0]  resp_id0;
  logic [31:0] cmds0;
  logic [63:0] bytes0;

  int checks = 0;
  int failures = 0;
  cmd_t sb_q[$];

  always #5 clk = ~clk;

  nic_cmd_responder dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_req_valid_i(req_valid), .cmd_req_ready_o(req_ready),
    .cmd_req_id_i(req_id), .cmd_req_length_i(req_len),
    .cmd_resp_valid_o(resp_valid), .cmd_resp_ready_i(resp_ready),
    .cmd_resp_id_o(resp_id), .busy_o(busy),
    .cmds_completed_o(cmds), .bytes_sent_o(bytes_sent)
  );

  nic_cmd_responder #(.FixedLatency(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .cmd_req_valid_i(req_valid0), .cmd_req_ready_o(req_ready0),
    .cmd_req_id_i(req_id0), .cmd_req_length_i(req_len0),
    .cmd_resp_valid_o(resp_valid0), .cmd_resp_ready_i(resp_ready0),
    .cmd_resp_id_o(resp_id0), .busy_o(busy0),
    .cmds_completed_o(cmds0), .bytes_sent_o(bytes0)
  );

  // Handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid && resp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL resp_order: unexpected completion id=%0h, expected none", resp_id);
        end else begin
          cmd_t e;
          e = sb_q.pop_front();
          if (resp_id !== e.id) begin
            failures++;
            $display("FAIL resp_order: id=%0h expected=%0h", resp_id, e.id);
          end
        end
      end
      if (req_valid && req_ready) sb_q.push_back('{id: req_id, len: req_len});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] id, input logic [31:0] len);
    int ok = 0;
    req_valid = 1'b1; req_id = id; req_len = len;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (ok != 1) begin
      failures++;
      $display("FAIL send_timeout: id=%0h accepted=%0d expected=1", id, ok);
    end
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (resp_valid) break;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_id !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%0h busy=%b expected 1 0 0 0",
               req_ready, resp_valid, resp_id, busy);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (cmds !== 32'd0 || bytes_sent !== 64'd0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_counters: cmds=%0d bytes=%0d ready=%b expected 0 0 1", cmds, bytes_sent, req_ready);
    end
  endtask

  task automatic test_single();
    int n;
    resp_ready = 1'b1;
    send_cmd(8'h05, 32'd128);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy: busy=%b expected=1", busy);
    end
    wait_resp(n);
    checks++;
    if (n != 13 || resp_id !== 8'h05) begin
      failures++;
      $display("FAIL single_latency: edges=%0d id=%0h expected 13 05", n, resp_id);
    end
    tick();
    checks++;
    if (cmds !== 32'd1 || bytes_sent !== 64'd128 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_done: cmds=%0d bytes=%0d busy=%b valid=%b expected 1 128 0 0",
               cmds, bytes_sent, busy, resp_valid);
    end
  endtask

  task automatic test_async_reset();
    send_cmd(8'h09, 32'd64);
    tick(); tick();
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_id !== 8'h00 || busy !== 1'b0 ||
        cmds !== 32'd0 || bytes_sent !== 64'd0) begin
      failures++;
      $display("FAIL async_reset: ready=%b valid=%b id=%0h busy=%b cmds=%0d bytes=%0d expected 1 0 0 0 0 0",
               req_ready, resp_valid, resp_id, busy, cmds, bytes_sent);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_min_latency();
    int n;
    logic [31:0] lens [2];
    int exp_n [2];
    lens[0] = 32'd0;  exp_n[0] = 2;
    lens[1] = 32'd65; exp_n[1] = 3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req_ready0 !== 1'b1) begin
        failures++;
        $display("FAIL min_ready: ready=%b expected=1", req_ready0);
      end
      req_valid0 = 1'b1; req_id0 = 8'h33 + 8'(k); req_len0 = lens[k];
      tick();
      req_valid0 = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        tick(); n++;
        if (resp_valid0) break;
      end
      checks++;
      if (n != exp_n[k] || resp_id0 !== 8'h33 + 8'(k)) begin
        failures++;
        $display("FAIL min_latency: len=%0d edges=%0d id=%0h expected %0d %0h",
                 lens[k], n, resp_id0, exp_n[k], 8'h33 + 8'(k));
      end
      tick();
      checks++;
      if (cmds0 !== 32'(k + 1) || bytes0 !== 64'(k * 65) || busy0 !== 1'b0) begin
        failures++;
        $display("FAIL min_counters: cmds=%0d bytes=%0d busy=%b expected %0d %0d 0",
                 cmds0, bytes0, busy0, k + 1, k * 65);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    resp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_cmd(8'(i), 32'd64);
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL full_ready: ready=%b busy=%b expected 0 1", req_ready, busy);
    end
    req_valid = 1'b1; req_id = 8'h05; req_len = 32'd64;
    wait_resp(n);
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 8'h01) begin
      failures++;
      $display("FAIL first_resp: valid=%b id=%0h expected 1 01", resp_valid, resp_id);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 8'h01 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL resp_stall: cycle=%0d valid=%b id=%0h ready=%b expected 1 01 0",
                 i, resp_valid, resp_id, req_ready);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_rise: ready=%b expected=1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL held_accept: ready=%b expected=0", req_ready);
    end
    wait_resp(n);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    wait_resp(n);
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL pre_simul: valid=%b ready=%b expected 1 1", resp_valid, req_ready);
    end
    req_valid = 1'b1; req_id = 8'h06; req_len = 32'd64; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0; resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_hs: ready=%b expected=1", req_ready);
    end
    send_cmd(8'h07, 32'd64);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_count: ready=%b expected=0", req_ready);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0 || sb_q.size() != 0 || cmds !== 32'd7 || bytes_sent !== 64'd448) begin
      failures++;
      $display("FAIL drain: busy=%b left=%0d cmds=%0d bytes=%0d expected 0 0 7 448",
               busy, sb_q.size(), cmds, bytes_sent);
    end
  endtask

  task automatic test_reset_in_xfer();
    int n;
    int seen = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_cmd(8'h40 + 8'(i), 32'd128);
    tick(); tick(); tick();
    #3 rst = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || cmds !== 32'd0) begin
      failures++;
      $display("FAIL xfer_reset: busy=%b valid=%b cmds=%0d expected 0 0 0", busy, resp_valid, cmds);
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0 || cmds !== 32'd0 || bytes_sent !== 64'd0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL dropped: resp_cycles=%0d cmds=%0d bytes=%0d ready=%b expected 0 0 0 1",
               seen, cmds, bytes_sent, req_ready);
    end
    send_cmd(8'h77, 32'd128);
    wait_resp(n);
    checks++;
    if (n != 13 || resp_id !== 8'h77) begin
      failures++;
      $display("FAIL post_reset_latency: edges=%0d id=%0h expected 13 77", n, resp_id);
    end
    tick();
    checks++;
    if (cmds !== 32'd1 || bytes_sent !== 64'd128 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_done: cmds=%0d bytes=%0d busy=%b expected 1 128 0", cmds, bytes_sent, busy);
    end
  endtask

  task automatic test_long_len();
    longint unsigned exp_l;
    exp_l = 64'd10 + ((64'hFFFF_FFFF + 64'd63) >> 6);
    do_reset();
    send_cmd(8'hAA, 32'hFFFF_FFFF);
    tick();
    checks++;
    if (64'(dut.timer_q) !== exp_l) begin
      failures++;
      $display("FAIL long_load: timer=%0d expected=%0d", 64'(dut.timer_q), exp_l);
    end
    tick();
    checks++;
    if (64'(dut.timer_q) !== exp_l - 64'd1 || busy !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL long_count: timer=%0d busy=%b valid=%b expected %0d 1 0",
               64'(dut.timer_q), busy, resp_valid, exp_l - 64'd1);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_async_reset();
    test_min_latency();
    test_backpressure();
    test_reset_in_xfer();
    test_long_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
